// File: rtl/crypto_test_jtag_pkg.sv
// Shared types and constants for the crypto test virtual-JTAG scan master.
package crypto_test_jtag_pkg;

    localparam int IR_WIDTH_DEF = 2;
    localparam int DR_WIDTH_DEF = 38;

    localparam logic [1:0] OCIMEM_A = 2'b00;
    localparam logic [1:0] OCIMEM_B = 2'b01;
    localparam logic [1:0] TRACEMEM = 2'b10;
    localparam logic [1:0] BREAK    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } state_e;

endpackage

// File: rtl/crypto_test_jtag_scan_master_tck_gen.sv
// Scan clock divider: tck low half first, TCK_DIV clk cycles per half, held low when disabled.
module crypto_test_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic tck_rise,
    output logic tck_fall
);

    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          tck_q, tck_d;
    logic          half_end;

    // tck_rise/tck_fall flag the cycle whose closing clk edge moves tck
    always_comb begin
        half_end = (32'(div_q) == TCK_DIV - 1);
        tck_rise = en && half_end && !tck_q;
        tck_fall = en && half_end && tck_q;
        div_d    = div_q;
        tck_d    = tck_q;
        if (!en) begin
            div_d = '0;
            tck_d = 1'b0;
        end else if (half_end) begin
            div_d = '0;
            tck_d = !tck_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            tck_q <= tck_d;
        end
    end

    assign tck = tck_q;

endmodule

// File: rtl/crypto_test_jtag_scan_master.sv
// Virtual-JTAG scan master: per command one IR update and one DR scan, captured tdo returned.
// Define CRYPTO_TEST_JTAG_SCAN_RTI_EN to dwell RTI_CYCLES tck periods in run-test-idle.
module crypto_test_jtag_scan_master
    import crypto_test_jtag_pkg::*;
#(
    parameter int IR_WIDTH   = IR_WIDTH_DEF,
    parameter int DR_WIDTH   = DR_WIDTH_DEF,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    input  logic [5:0]          cmd_len,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    // Counter also paces run-test-idle, so RTI_CYCLES must fit in CNT_W bits
    localparam int CNT_W = $clog2(DR_WIDTH + 1);

    state_e              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [DR_WIDTH-1:0] dr_q, dr_d, cap_q, cap_d;
    logic [CNT_W-1:0]    len_q, len_d, cnt_q, cnt_d, eff_len;
    logic                tdi_q, tdi_d;
    logic                tck_en, tck_rise, tck_fall;

    assign tck_en = state_q inside {ST_UIR, ST_CDR, ST_SDR, ST_UDR, ST_RTI};

    crypto_test_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (tck_en),
        .tck      (vji_tck),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall)
    );

    always_comb begin
        if (cmd_len == 6'd0 || 32'(cmd_len) > DR_WIDTH) eff_len = CNT_W'(DR_WIDTH);
        else                                             eff_len = CNT_W'(cmd_len);
    end

    // Period boundaries are tck falling edges; tdi moves only there
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        dr_d    = dr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        tdi_d   = tdi_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                state_d = ST_UIR;
                ir_d    = cmd_ir;
                dr_d    = cmd_dr;
                len_d   = eff_len;
                cap_d   = '0;
                cnt_d   = '0;
            end
            ST_UIR: if (tck_fall) state_d = ST_CDR;
            ST_CDR: if (tck_fall) begin
                state_d = ST_SDR;
                tdi_d   = dr_q[0];
                dr_d    = dr_q >> 1;
                cnt_d   = '0;
            end
            ST_SDR: begin
                if (tck_rise) cap_d[cnt_q] = vji_tdo;
                if (tck_fall) begin
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = ST_UDR;
                        tdi_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        tdi_d = dr_q[0];
                        dr_d  = dr_q >> 1;
                    end
                end
            end
            ST_UDR: if (tck_fall) begin
`ifdef CRYPTO_TEST_JTAG_SCAN_RTI_EN
                state_d = ST_RTI;
                cnt_d   = '0;
`else
                state_d = ST_RSP;
`endif
            end
            ST_RTI: if (tck_fall) begin
                if (32'(cnt_q) == RTI_CYCLES - 1) state_d = ST_RSP;
                else                              cnt_d   = cnt_q + 1'b1;
            end
            ST_RSP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            tdi_q   <= tdi_d;
        end
    end

    always_ff @(posedge clk) begin
        dr_q  <= dr_d;
        len_q <= len_d;
    end

    assign cmd_ready = reset_n && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_dr    = cap_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_q;
    assign vji_uir   = (state_q == ST_UIR);
    assign vji_cdr   = (state_q == ST_CDR);
    assign vji_sdr   = (state_q == ST_SDR);
    assign vji_udr   = (state_q == ST_UDR);
`ifdef CRYPTO_TEST_JTAG_SCAN_RTI_EN
    assign vji_rti   = (state_q == ST_RTI);
`else
    assign vji_rti   = 1'b0;
`endif

endmodule

// File: tb/tb_crypto_test_jtag_scan_master.sv
// Directed bench for crypto_test_jtag_scan_master: default divider instance plus a TCK_DIV=1 instance.
`timescale 1ns/1ps
module tb_crypto_test_jtag_scan_master;

`ifdef CRYPTO_TEST_JTAG_SCAN_RTI_EN
    localparam int RTI_P = 4;
`else
    localparam int RTI_P = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0]  cmd_ir, vji_ir_in;
    logic [37:0] cmd_dr, rsp_dr;
    logic [5:0]  cmd_len;
    logic        vji_tck, vji_tdi, vji_tdo, tdo_one;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    logic        c1_cmd_valid, c1_cmd_ready, c1_rsp_valid, c1_rsp_ready;
    logic [1:0]  c1_cmd_ir, c1_ir_in;
    logic [37:0] c1_cmd_dr, c1_rsp_dr;
    logic [5:0]  c1_cmd_len;
    logic        c1_tck, c1_tdi, c1_tdo;
    logic        c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti;

    assign vji_tdo = tdo_one ? 1'b1 : vji_tdi;
    assign c1_tdo  = c1_tdi;

    crypto_test_jtag_scan_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    crypto_test_jtag_scan_master #(.TCK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(c1_cmd_valid), .cmd_ready(c1_cmd_ready), .cmd_ir(c1_cmd_ir), .cmd_dr(c1_cmd_dr), .cmd_len(c1_cmd_len),
        .rsp_valid(c1_rsp_valid), .rsp_ready(c1_rsp_ready), .rsp_dr(c1_rsp_dr),
        .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_tdo(c1_tdo), .vji_ir_in(c1_ir_in),
        .vji_uir(c1_uir), .vji_cdr(c1_cdr), .vji_sdr(c1_sdr), .vji_udr(c1_udr), .vji_rti(c1_rti)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int sdr_rises = 0, rti_cyc = 0, onehot_err = 0, tck_err = 0, tdi_err = 0, gap_err = 0;
    logic [4:0] seq_q[$];
    logic [4:0] prev_code = '0;
    logic       prev_tck = 1'b0, prev_tdi = 1'b0, c1_prev_tck = 1'b0;
    int         gap = 0, c1_gap = 0;
    bit         have = 1'b0, c1_have = 1'b0;

    // Protocol monitors, sampled on the inactive clock edge
    always @(negedge clk) begin
        logic [4:0] code, c1_code;
        code    = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
        c1_code = {c1_uir, c1_cdr, c1_sdr, c1_udr, c1_rti};
        if ($countones(code) > 1 || $countones(c1_code) > 1) onehot_err++;
        if ((vji_tck && code == 5'b0) || (c1_tck && c1_code == 5'b0)) tck_err++;
        if (reset_n && vji_tdi !== prev_tdi && !(prev_tck && !vji_tck)) tdi_err++;
        if (vji_tck && !prev_tck && vji_sdr) sdr_rises++;
        if (vji_rti) rti_cyc++;
        if (code != prev_code && code != 5'b0) seq_q.push_back(code);
        if (code == 5'b0) begin
            have = 1'b0; gap = 0;
        end else begin
            gap++;
            if (vji_tck && !prev_tck) begin
                if (have && gap != 4) gap_err++;
                have = 1'b1; gap = 0;
            end
        end
        if (c1_code == 5'b0) begin
            c1_have = 1'b0; c1_gap = 0;
        end else begin
            c1_gap++;
            if (c1_tck && !c1_prev_tck) begin
                if (c1_have && c1_gap != 2) gap_err++;
                c1_have = 1'b1; c1_gap = 0;
            end
        end
        prev_code   = code;
        prev_tck    = vji_tck;
        prev_tdi    = vji_tdi;
        c1_prev_tck = c1_tck;
    end

    // Offers one command on dut, then waits (bounded) for its response
    task automatic issue(input logic [1:0] ir, input logic [37:0] dr, input logic [5:0] len,
                         output int lat, output logic first_uir, output logic first_tck);
        int n;
        cmd_ir = ir; cmd_dr = dr; cmd_len = len; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        first_uir = vji_uir;
        first_tck = vji_tck;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; tdo_one = 1'b0;
        cmd_ir = '0; cmd_dr = '0; cmd_len = '0;
        c1_cmd_valid = 1'b0; c1_rsp_ready = 1'b1; c1_cmd_ir = '0; c1_cmd_dr = '0; c1_cmd_len = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: ready=%b valid=%b expected 0 0", cmd_ready, rsp_valid);
        end
        n_checks++;
        if (rsp_dr !== 38'h0 || vji_ir_in !== 2'b00) begin
            n_fail++; $display("FAIL reset_data: rsp_dr=%h ir_in=%b expected 0 0", rsp_dr, vji_ir_in);
        end
        n_checks++;
        if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} !== 7'b0) begin
            n_fail++; $display("FAIL reset_jtag: tck/tdi/strobes=%b expected 0000000",
                               {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti});
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || c1_cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b%b expected 11", cmd_ready, c1_cmd_ready);
        end
    endtask

    task automatic test_loopback;
        int lat, b_sdr, b_rti, b_seq, n_seq, exp_n;
        logic fu, ft;
        logic [4:0] exp_seq [5];
        bit seq_ok;
        exp_seq = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        exp_n = (RTI_P > 0) ? 5 : 4;
        b_sdr = sdr_rises; b_rti = rti_cyc; b_seq = seq_q.size();
        tdo_one = 1'b0; rsp_ready = 1'b1;
        issue(2'b01, 38'h2_A5A5_A5A5, 6'd0, lat, fu, ft);
        n_checks++;
        if (rsp_dr !== 38'h2_A5A5_A5A5) begin
            n_fail++; $display("FAIL loop_rsp_dr: got %h expected %h", rsp_dr, 38'h2_A5A5_A5A5);
        end
        n_checks++;
        if (lat != 4 * (3 + 38 + RTI_P) + 1) begin
            n_fail++; $display("FAIL loop_latency: got %0d expected %0d", lat, 4 * (3 + 38 + RTI_P) + 1);
        end
        n_checks++;
        if (sdr_rises - b_sdr != 38) begin
            n_fail++; $display("FAIL loop_sdr_periods: got %0d expected 38", sdr_rises - b_sdr);
        end
        n_checks++;
        if (rti_cyc - b_rti != 4 * RTI_P) begin
            n_fail++; $display("FAIL loop_rti_cycles: got %0d expected %0d", rti_cyc - b_rti, 4 * RTI_P);
        end
        n_seq = seq_q.size() - b_seq;
        seq_ok = (n_seq == exp_n);
        if (seq_ok) for (int i = 0; i < n_seq; i++) if (seq_q[b_seq + i] !== exp_seq[i]) seq_ok = 1'b0;
        n_checks++;
        if (!seq_ok) begin
            n_fail++; $display("FAIL loop_strobe_sequence: got %0d strobe phases expected %0d in order", n_seq, exp_n);
        end
        n_checks++;
        if (fu !== 1'b1 || ft !== 1'b0 || vji_ir_in !== 2'b01) begin
            n_fail++; $display("FAIL loop_uir_entry: uir=%b tck=%b ir_in=%b expected 1 0 01", fu, ft, vji_ir_in);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL loop_return_idle: valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_len8;
        int lat, b_sdr;
        logic fu, ft;
        b_sdr = sdr_rises;
        tdo_one = 1'b1; rsp_ready = 1'b1;
        issue(2'b10, 38'hC3, 6'd8, lat, fu, ft);
        n_checks++;
        if (rsp_dr !== 38'h00_0000_00FF) begin
            n_fail++; $display("FAIL len8_rsp_dr: got %h expected %h", rsp_dr, 38'hFF);
        end
        n_checks++;
        if (sdr_rises - b_sdr != 8 || lat != 4 * (3 + 8 + RTI_P) + 1) begin
            n_fail++; $display("FAIL len8_timing: sdr=%0d lat=%0d expected 8 %0d", sdr_rises - b_sdr, lat, 4 * (11 + RTI_P) + 1);
        end
        n_checks++;
        if (vji_ir_in !== 2'b10) begin
            n_fail++; $display("FAIL len8_ir_in: got %b expected 10", vji_ir_in);
        end
        @(negedge clk);
    endtask

    task automatic test_len_edges;
        int lat, b_sdr;
        logic fu, ft;
        b_sdr = sdr_rises;
        tdo_one = 1'b0; rsp_ready = 1'b1;
        issue(2'b11, 38'h3_0F0F_1234, 6'd50, lat, fu, ft);
        n_checks++;
        if (rsp_dr !== 38'h3_0F0F_1234 || sdr_rises - b_sdr != 38) begin
            n_fail++; $display("FAIL clamp_len50: rsp=%h sdr=%0d expected %h 38", rsp_dr, sdr_rises - b_sdr, 38'h3_0F0F_1234);
        end
        @(negedge clk);
        b_sdr = sdr_rises;
        issue(2'b00, 38'h3F_FFFF_FFFF, 6'd1, lat, fu, ft);
        n_checks++;
        if (rsp_dr !== 38'h1 || sdr_rises - b_sdr != 1 || lat != 4 * (4 + RTI_P) + 1) begin
            n_fail++; $display("FAIL len1: rsp=%h sdr=%0d lat=%0d expected 1 1 %0d", rsp_dr, sdr_rises - b_sdr, lat, 4 * (4 + RTI_P) + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_tck_div1;
        int lat;
        c1_cmd_ir = 2'b10; c1_cmd_dr = 38'h16; c1_cmd_len = 6'd5; c1_cmd_valid = 1'b1; c1_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c1_cmd_valid = 1'b0;
        lat = 1;
        while (!c1_rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 2 * (3 + 5 + RTI_P) + 1) begin
            n_fail++; $display("FAIL div1_latency: got %0d expected %0d", lat, 2 * (3 + 5 + RTI_P) + 1);
        end
        n_checks++;
        if (c1_rsp_dr !== 38'h16 || c1_ir_in !== 2'b10) begin
            n_fail++; $display("FAIL div1_data: rsp=%h ir=%b expected 16 10", c1_rsp_dr, c1_ir_in);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat, bad;
        logic fu, ft;
        tdo_one = 1'b0; rsp_ready = 1'b0;
        issue(2'b00, 38'h5A, 6'd8, lat, fu, ft);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_dr !== 38'h5A) begin
            n_fail++; $display("FAIL bp_first_rsp: valid=%b rsp=%h expected 1 5a", rsp_valid, rsp_dr);
        end
        cmd_ir = 2'b01; cmd_dr = 38'h9; cmd_len = 6'd4; cmd_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_dr !== 38'h5A) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || vji_uir !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle: ready=%b valid=%b uir=%b expected 1 0 0", cmd_ready, rsp_valid, vji_uir);
        end
        @(negedge clk);
        n_checks++;
        if (vji_uir !== 1'b1) begin
            n_fail++; $display("FAIL bp_second_start: uir=%b expected 1", vji_uir);
        end
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
        n_checks++;
        if (rsp_dr !== 38'h9 || lat != 4 * (3 + 4 + RTI_P) + 1) begin
            n_fail++; $display("FAIL bp_second_rsp: rsp=%h lat=%0d expected 9 %0d", rsp_dr, lat, 4 * (7 + RTI_P) + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, b_sdr, n, seen;
        logic fu, ft;
        tdo_one = 1'b0; rsp_ready = 1'b1;
        cmd_ir = 2'b11; cmd_dr = 38'h15_5555_5555; cmd_len = 6'd0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        b_sdr = sdr_rises;
        n = 0;
        while (sdr_rises - b_sdr < 10 && n < 500) begin @(negedge clk); n++; end
        while (vji_tck && n < 500) begin @(negedge clk); n++; end
        n_checks++;
        if (vji_sdr !== 1'b1) begin
            n_fail++; $display("FAIL mid_reach_sdr: sdr=%b expected 1", vji_sdr);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, cmd_ready, rsp_valid} !== 9'b0) begin
            n_fail++; $display("FAIL mid_abort: outputs=%b expected 000000000",
                               {vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, cmd_ready, rsp_valid});
        end
        seen = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
        reset_n = 1'b1;
        repeat (20) begin @(negedge clk); if (rsp_valid) seen++; end
        n_checks++;
        if (seen != 0 || vji_ir_in !== 2'b00) begin
            n_fail++; $display("FAIL mid_no_partial: rsp cycles=%0d ir_in=%b expected 0 00", seen, vji_ir_in);
        end
        tdo_one = 1'b1;
        issue(2'b01, 38'h0, 6'd3, lat, fu, ft);
        n_checks++;
        if (rsp_dr !== 38'h7 || lat != 4 * (6 + RTI_P) + 1 || vji_ir_in !== 2'b01) begin
            n_fail++; $display("FAIL mid_fresh_cmd: rsp=%h lat=%0d ir=%b expected 7 %0d 01", rsp_dr, lat, vji_ir_in, 4 * (6 + RTI_P) + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_invariants;
        n_checks++;
        if (onehot_err != 0 || tck_err != 0) begin
            n_fail++; $display("FAIL strobe_exclusive: onehot=%0d tck_outside=%0d expected 0 0", onehot_err, tck_err);
        end
        n_checks++;
        if (tdi_err != 0 || gap_err != 0) begin
            n_fail++; $display("FAIL tck_tdi_timing: tdi_changes=%0d period_errs=%0d expected 0 0", tdi_err, gap_err);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_len8();
        test_len_edges();
        test_tck_div1();
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
